nic_sequencer: RTL

Autonomous host-side controller for the node's network interface register port. It accepts outbound 64-bit words from the processor/DMA side into a TX FIFO and writes them into the NIC. It also polls the NIC input status, drains arriving words into an RX FIFO, and alternates fairly between the two services. It sits between the core's memory-mapped I/O path and the NIC, so software no longer spin-polls status registers.

---
 rtl/nic_pkg.sv | 21 ++
 rtl/nic_word_fifo.sv | 58 +++++
 rtl/nic_sequencer.sv | 111 +++++++++++
 3 files changed

// File: rtl/nic_pkg.sv
// Shared constants and types for the NIC register-port sequencer.
package nic_pkg;
    localparam logic [1:0] NIC_OUT_BUF  = 2'b00;
    localparam logic [1:0] NIC_OUT_STAT = 2'b01;
    localparam logic [1:0] NIC_IN_BUF   = 2'b10;
    localparam logic [1:0] NIC_IN_STAT  = 2'b11;
    localparam int         NIC_STATUS_BIT = 63;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POLL_OUT,
        ST_WRITE_OUT,
        ST_POLL_IN,
        ST_READ_IN
    } state_t;

    typedef enum logic {
        SVC_TX = 1'b0,
        SVC_RX = 1'b1
    } svc_t;
endpackage

// File: rtl/nic_word_fifo.sv
// First-word-fall-through FIFO of 64-bit words; full refuses pushes even when popping.
module nic_word_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic [0:63] push_data,
    input  logic        pop,
    output logic        full,
    output logic        empty,
    output logic [0:63] head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [0:63]   mem_q [DEPTH];
    logic [0:63]   mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/nic_sequencer.sv
// Alternates TX writes and RX drains over the NIC register port; NIC outputs decode from state only.
module nic_sequencer
    import nic_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [0:63] tx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [0:63] rx_data,
    output logic [0:1]  nic_addr,
    output logic        nic_en,
    output logic        nic_wr_en,
    output logic [0:63] nic_d_in,
    input  logic [0:63] nic_d_out,
    output logic        busy
);
    state_t      state_q, state_d;
    svc_t        last_svc_q, last_svc_d;
    logic        tx_full, tx_empty, rx_full, rx_empty;
    logic        tx_pop, rx_push, tx_elig, rx_elig;
    logic [0:63] tx_head;

    assign tx_ready = !tx_full;
    assign rx_valid = !rx_empty;
    assign tx_elig  = !tx_empty;
    assign rx_elig  = !rx_full;
    assign busy     = (state_q != ST_IDLE) || !tx_empty || !rx_empty;

    nic_word_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset),
        .push(tx_valid), .push_data(tx_data), .pop(tx_pop),
        .full(tx_full), .empty(tx_empty), .head(tx_head)
    );

    nic_word_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset),
        .push(rx_push), .push_data(nic_d_out), .pop(rx_ready),
        .full(rx_full), .empty(rx_empty), .head(rx_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            last_svc_q <= SVC_RX;
        end else begin
            state_q    <= state_d;
            last_svc_q <= last_svc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_svc_d = last_svc_q;
        nic_addr   = NIC_OUT_BUF;
        nic_en     = 1'b0;
        nic_wr_en  = 1'b0;
        nic_d_in   = '0;
        tx_pop     = 1'b0;
        rx_push    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // When both sides want service, the one not served last goes first.
                if (tx_elig && (!rx_elig || last_svc_q == SVC_RX)) state_d = ST_POLL_OUT;
                else if (rx_elig)                                 state_d = ST_POLL_IN;
            end
            ST_POLL_OUT: begin
                nic_addr = NIC_OUT_STAT;
                nic_en   = 1'b1;
                if (!nic_d_out[NIC_STATUS_BIT]) begin
                    state_d = ST_WRITE_OUT;
                end else begin
                    state_d    = ST_IDLE;
                    last_svc_d = SVC_TX;
                end
            end
            ST_WRITE_OUT: begin
                nic_addr   = NIC_OUT_BUF;
                nic_en     = 1'b1;
                nic_wr_en  = 1'b1;
                nic_d_in   = tx_head;
                tx_pop     = 1'b1;
                last_svc_d = SVC_TX;
                state_d    = ST_IDLE;
            end
            ST_POLL_IN: begin
                nic_addr = NIC_IN_STAT;
                nic_en   = 1'b1;
                if (nic_d_out[NIC_STATUS_BIT]) begin
                    state_d = ST_READ_IN;
                end else begin
                    state_d    = ST_IDLE;
                    last_svc_d = SVC_RX;
                end
            end
            ST_READ_IN: begin
                // RX space was confirmed in IDLE and nothing else pushes RX.
                nic_addr   = NIC_IN_BUF;
                nic_en     = 1'b1;
                rx_push    = 1'b1;
                last_svc_d = SVC_RX;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end
endmodule
